// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit unsigned subtractor: one full-subtract cell (two half
// subtractors) sequenced LSB first, one bit per clock, with start/busy/done handshake.

module half_subtractor (
  input  logic x_i,
  input  logic y_i,
  output logic d_o,
  output logic b_o
);
  assign d_o = x_i ^ y_i;
  assign b_o = ~x_i & y_i;
endmodule

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {IDLE, SUB} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d, res_q, res_d, diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bin_q, bin_d, busy_q, busy_d, done_q, done_d;
  logic               borrow_q, borrow_d;
  logic               d1, b1, b2, d_bit, bout;

  // Full subtract cell: first stage takes sa-sb, second subtracts incoming borrow.
  half_subtractor u_hs0 (.x_i(sa_q[0]), .y_i(sb_q[0]), .d_o(d1),    .b_o(b1));
  half_subtractor u_hs1 (.x_i(d1),      .y_i(bin_q),   .d_o(d_bit), .b_o(b2));
  assign bout = b1 | b2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SUB;
          sa_d    = a;
          sb_d    = b;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SUB: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        bin_d = bout;
        cnt_d = cnt_q + CNT_W'(1);
        // Last bit: publish the full result only now so diff never shows partials.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = IDLE;
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = bout;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
endmodule
